// File: rtl/vga_draw_arbiter_if.sv
// Bundle between the per-object draw engines and the VGA pixel-write arbiter.
// master = draw-engine side, slave = arbiter side.
interface vga_draw_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   req_done;
   logic [8*N_REQ-1:0] req_x;
   logic [7*N_REQ-1:0] req_y;
   logic [3*N_REQ-1:0] req_color;
   logic [N_REQ-1:0]   req_write;
   logic [N_REQ-1:0]   gnt;
   logic [7:0]         vga_x;
   logic [6:0]         vga_y;
   logic [2:0]         vga_color;
   logic               vga_write;
   logic               busy;
   logic               timeout;

   modport master (
      output req, req_done, req_x, req_y, req_color, req_write,
      input  gnt, vga_x, vga_y, vga_color, vga_write, busy, timeout
   );

   modport slave (
      input  req, req_done, req_x, req_y, req_color, req_write,
      output gnt, vga_x, vga_y, vga_color, vga_write, busy, timeout
   );
endinterface

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA adapter pixel-write port, one engine per burst.
// Optional grant watchdog is built in when ARB_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no grant; pick next requester round-robin from last_ptr+1
// GRANT   | forward granted requester's pixel stream, 1-cycle latency
// RELEASE | one-cycle settle gap, gnt = 0, vga_write = 0
module vga_draw_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 64
) (
   input  logic              clk,
   input  logic              reset,
   vga_draw_arbiter_if.slave bus
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;

   state_t           state_q;
   logic [N_REQ-1:0] gnt_q;
   logic [PTR_W-1:0] last_ptr_q;
   logic [7:0]       vga_x_q;
   logic [6:0]       vga_y_q;
   logic [2:0]       vga_color_q;
   logic             vga_write_q;
   logic             busy_q;

   logic [7:0] fx [N_REQ];
   logic [6:0] fy [N_REQ];
   logic [2:0] fc [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign fx[i] = bus.req_x[8*i +: 8];
      assign fy[i] = bus.req_y[7*i +: 7];
      assign fc[i] = bus.req_color[3*i +: 3];
   end

   // Walk offsets downward so the nearest requester after last_ptr wins.
   logic [PTR_W-1:0] sel_d;
   logic [PTR_W-1:0] rr_idx;
   logic             req_any;

   always_comb begin
      sel_d   = last_ptr_q;
      rr_idx  = '0;
      req_any = 1'b0;
      for (int off = N_REQ; off >= 1; off--) begin
         rr_idx = PTR_W'((int'(last_ptr_q) + off) % N_REQ);
         if (bus.req[rr_idx]) begin
            sel_d   = rr_idx;
            req_any = 1'b1;
         end
      end
   end

   logic g_req;
   logic g_done;
   logic g_write;

   assign g_req   = bus.req[last_ptr_q];
   assign g_done  = bus.req_done[last_ptr_q];
   assign g_write = bus.req_write[last_ptr_q];

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_q;
   logic       timeout_q;
   assign bus.timeout = timeout_q;
`else
   localparam int UNUSED_MAX_HOLD = MAX_HOLD;
   assign bus.timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         last_ptr_q  <= PTR_W'(N_REQ - 1);
         vga_x_q     <= '0;
         vga_y_q     <= '0;
         vga_color_q <= '0;
         vga_write_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_q      <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         vga_write_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         timeout_q   <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (req_any) begin
                  state_q    <= GRANT;
                  gnt_q      <= N_REQ'(1) << sel_d;
                  last_ptr_q <= sel_d;
                  busy_q     <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  hold_q     <= '0;
`endif
               end
            end
            GRANT: begin
               vga_x_q     <= fx[last_ptr_q];
               vga_y_q     <= fy[last_ptr_q];
               vga_color_q <= fc[last_ptr_q];
               vga_write_q <= g_write;
               if (g_done || !g_req) begin
                  state_q <= RELEASE;
                  gnt_q   <= '0;
               end
`ifdef ARB_TIMEOUT_EN
               else if (hold_q == HOLD_LAST) begin
                  state_q   <= RELEASE;
                  gnt_q     <= '0;
                  timeout_q <= 1'b1;
               end else begin
                  hold_q <= hold_q + 8'd1;
               end
`endif
            end
            RELEASE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.vga_x     = vga_x_q;
   assign bus.vga_y     = vga_y_q;
   assign bus.vga_color = vga_color_q;
   assign bus.vga_write = vga_write_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: pixel scoreboard keyed by expected arrival cycle,
// round-robin reference model, reset, gap and watchdog checks.
module tb_vga_draw_arbiter;
   localparam int N = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_asserts = 0;
   int   n_fail    = 0;
   int   m_last;
   int   pick;
   int   order [5];

   logic [49:0] sb_q [$];

   vga_draw_arbiter_if #(.N_REQ(N)) bus ();

   vga_draw_arbiter #(.N_REQ(N), .MAX_HOLD(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [49:0] obs, input logic [49:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [3:0] r);
      for (int o = 1; o <= N; o++)
         if (r[(last + o) % N]) return (last + o) % N;
      return -1;
   endfunction

   function automatic logic [3:0] oh(input int i);
      logic [3:0] v;
      v = 4'b0001 << i;
      return v;
   endfunction

   // Each expected pixel carries the cycle it must appear on the adapter.
   always @(negedge clk) begin
      logic        exp_w;
      logic [49:0] e;
      if (!reset) begin
         exp_w = (sb_q.size() != 0) && (sb_q[0][31:0] == 32'(cyc));
         chk("vga_write", bus.vga_write, exp_w);
         if (exp_w) begin
            e = sb_q.pop_front();
            chk("pixel", {bus.vga_x, bus.vga_y, bus.vga_color, 32'(cyc)}, e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input int r, input logic [7:0] x, input logic [6:0] y,
                      input logic [2:0] c, input logic w, input logic d);
      bus.req_x[8*r +: 8]     = x;
      bus.req_y[7*r +: 7]     = y;
      bus.req_color[3*r +: 3] = c;
      bus.req_write[r]        = w;
      bus.req_done[r]         = d;
      if (w) sb_q.push_back({x, y, c, 32'(cyc + 1)});
   endtask

   task automatic burst(input int r, input int n, input logic [7:0] x0, input logic [6:0] y0);
      for (int k = 0; k < n; k++) begin
         pix(r, x0 + 8'(k % 4), y0 + 7'(k % 4), 3'(k), 1'b1, k == n - 1);
         tick();
      end
      bus.req_write[r] = 1'b0;
      bus.req_done[r]  = 1'b0;
   endtask

   initial begin
      bus.req = '0; bus.req_done = '0; bus.req_write = '0;
      bus.req_x = '0; bus.req_y = '0; bus.req_color = '0;
      order = '{0, 1, 2, 3, 0};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", bus.gnt, 4'b0000);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_vga_write", bus.vga_write, 1'b0);
      chk("rst_vga_xyc", {bus.vga_x, bus.vga_y, bus.vga_color}, 18'd0);
      chk("rst_timeout", bus.timeout, 1'b0);
      reset = 1'b0;
      m_last = N - 1;
      tick();

      // single 16-pixel burst from the ball engine
      bus.req = 4'b0001;
      tick();
      pick = rr_pick(m_last, 4'b0001); m_last = pick;
      chk("t1_gnt", bus.gnt, oh(pick));
      chk("t1_busy", bus.busy, 1'b1);
      burst(0, 16, 8'd70, 7'd50);
      bus.req = 4'b0000;
      chk("t1_release_gnt", bus.gnt, 4'b0000);
      chk("t1_release_busy", bus.busy, 1'b1);
      tick();
      chk("t1_idle_busy", bus.busy, 1'b0);
      tick();
      chk("t1_sb_empty", sb_q.size(), 0);

      // all four requesting: fair rotation with 2-cycle gaps
      reset = 1'b1; tick(); reset = 1'b0; m_last = N - 1;
      bus.req = 4'b1111;
      tick();
      for (int i = 0; i < 5; i++) begin
         pick = rr_pick(m_last, bus.req); m_last = pick;
         chk("t2_order", pick, order[i]);
         chk("t2_gnt", bus.gnt, oh(pick));
         burst(pick, 4, 8'(16 * pick + 1), 7'(10 * pick + 2));
         chk("t2_release_gnt", bus.gnt, 4'b0000);
         if (i == 4) bus.req = 4'b0000;
         tick();
         chk("t2_gap1_write", bus.vga_write, 1'b0);
         chk("t2_gap1_gnt", bus.gnt, 4'b0000);
         tick();
         chk("t2_gap2_write", bus.vga_write, 1'b0);
      end

      // non-granted requester 1 injects noise while 2 owns the port
      bus.req = 4'b0100;
      tick();
      pick = rr_pick(m_last, bus.req); m_last = pick;
      chk("t3_gnt", bus.gnt, oh(pick));
      bus.req[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.req_x[15:8]  = 8'hFF;
         bus.req_write[1] = k[0];
         bus.req_done[1]  = (k == 3);
         pix(2, 8'h20 + 8'(k), 7'h30 + 7'(k), 3'(k), (k % 3) != 0, k == 7);
         tick();
         if (k < 7) chk("t3_gnt_hold", bus.gnt, 4'b0100);
      end
      bus.req_write = '0; bus.req_done = '0; bus.req[2] = 1'b0;
      chk("t3_release_gnt", bus.gnt, 4'b0000);
      tick(); tick();
      pick = rr_pick(m_last, bus.req); m_last = pick;
      chk("t3_next_gnt", bus.gnt, oh(pick));
      burst(1, 2, 8'h40, 7'h11);
      bus.req = 4'b0000;
      tick(); tick();

      // async reset in the middle of a score burst
      bus.req = 4'b1000;
      tick();
      pick = rr_pick(m_last, bus.req); m_last = pick;
      chk("t4_gnt", bus.gnt, oh(pick));
      pix(3, 8'h55, 7'h22, 3'd5, 1'b1, 1'b0);
      tick();
      @(negedge clk);
      #1;
      bus.req_write[3] = 1'b1;
      reset = 1'b1;
      #1;
      chk("t4_async_gnt", bus.gnt, 4'b0000);
      chk("t4_async_write", bus.vga_write, 1'b0);
      chk("t4_async_busy", bus.busy, 1'b0);
      chk("t4_async_xyc", {bus.vga_x, bus.vga_y, bus.vga_color}, 18'd0);
      @(posedge clk);
      #1;
      reset = 1'b0; bus.req = '0; bus.req_write = '0;
      m_last = N - 1;
      bus.req = 4'b1001;
      tick();
      pick = rr_pick(m_last, bus.req); m_last = pick;
      chk("t4_first_after_reset", bus.gnt, 4'b0001);
      burst(0, 3, 8'h60, 7'h05);
      bus.req[0] = 1'b0;
      tick(); tick();
      pick = rr_pick(m_last, bus.req); m_last = pick;
      chk("t4_second_gnt", bus.gnt, oh(pick));
      burst(3, 1, 8'h70, 7'h06);
      bus.req = 4'b0000;
      tick(); tick();

      // requester 1 hangs on to its grant
      bus.req = 4'b0110;
      tick();
      pick = rr_pick(m_last, bus.req); m_last = pick;
      chk("t5_gnt", bus.gnt, 4'b0010);
`ifdef ARB_TIMEOUT_EN
      for (int i = 1; i < 64; i++) begin
         tick();
         chk("t5_hold_gnt", bus.gnt, 4'b0010);
         chk("t5_hold_timeout", bus.timeout, 1'b0);
      end
      tick();
      chk("t5_timeout_pulse", bus.timeout, 1'b1);
      chk("t5_timeout_gnt", bus.gnt, 4'b0000);
      bus.req[1] = 1'b0;
      tick();
      chk("t5_timeout_one_cycle", bus.timeout, 1'b0);
      tick();
`else
      for (int i = 1; i < 70; i++) begin
         tick();
         chk("t5_hold_gnt", bus.gnt, 4'b0010);
         chk("t5_hold_timeout", bus.timeout, 1'b0);
      end
      bus.req_done[1] = 1'b1;
      tick();
      bus.req_done[1] = 1'b0; bus.req[1] = 1'b0;
      chk("t5_release_gnt", bus.gnt, 4'b0000);
      tick(); tick();
`endif
      pick = rr_pick(m_last, bus.req); m_last = pick;
      chk("t5_pass_gnt", bus.gnt, 4'b0100);
      burst(2, 2, 8'h0A, 7'h0B);
      bus.req = 4'b0000;
      tick(); tick();

      // ball engine drops req without done
      bus.req = 4'b0001;
      tick();
      pick = rr_pick(m_last, bus.req); m_last = pick;
      chk("t6_gnt", bus.gnt, oh(pick));
      pix(0, 8'h12, 7'h13, 3'd1, 1'b1, 1'b0);
      tick();
      pix(0, 8'h14, 7'h15, 3'd2, 1'b1, 1'b0);
      tick();
      bus.req[0] = 1'b0; bus.req_write[0] = 1'b0;
      tick();
      chk("t6_release_gnt", bus.gnt, 4'b0000);
      chk("t6_release_busy", bus.busy, 1'b1);
      bus.req_write[0] = 1'b1; bus.req_x[7:0] = 8'hEE;
      repeat (4) tick();
      chk("t6_idle_busy", bus.busy, 1'b0);
      chk("t6_idle_gnt", bus.gnt, 4'b0000);
      bus.req_write = '0;
      tick();
      chk("final_sb_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
